// File: rtl/csync_pulse_timer_pkg.sv
// Shared encodings for the composite-sync pulse timer.
package csync_pulse_timer_pkg;

   localparam logic [1:0] KIND_NONE  = 2'd0;
   localparam logic [1:0] KIND_EQU   = 2'd1;
   localparam logic [1:0] KIND_HSYNC = 2'd2;
   localparam logic [1:0] KIND_BROAD = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HIGH,
      ST_LOW
   } state_t;

endpackage

// File: rtl/csync_pulse_timer_sync_deglitch.sv
// Two-flop synchroniser plus symmetric hold-time glitch filter.
module csync_pulse_timer_sync_deglitch #(
   parameter int GLITCH = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic level
);

   localparam logic [3:0] HOLD = 4'(GLITCH);

   logic       s1;
   logic       s2;
   logic [3:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1    <= 1'b1;
         s2    <= 1'b1;
         level <= 1'b1;
         cnt   <= '0;
      end else begin
         s1 <= din;
         s2 <= s1;
         if (s2 == level) begin
            cnt <= '0;
         end else if (cnt == HOLD - 4'd1) begin
            level <= ~level;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 4'd1;
         end
      end
   end

endmodule

// File: rtl/csync_pulse_timer.sv
// Measures and classifies low pulses on a composite-sync line.
module csync_pulse_timer
   import csync_pulse_timer_pkg::*;
#(
   parameter int GLITCH    = 4,
   parameter int CNT_W     = 16,
   parameter int MIN_PULSE = 250,
   parameter int SHORT_MAX = 1700,
   parameter int LONG_MIN  = 6000,
   parameter int BROAD_MIN = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             csync_in,
   output logic             pulse_valid,
   output logic [1:0]       pulse_kind,
   output logic [CNT_W-1:0] pulse_width,
   output logic [CNT_W-1:0] pulse_period,
   output logic             period_valid,
   output logic             frame_start,
   output logic             sync_level
);

   localparam logic [CNT_W-1:0] CMAX  = '1;
   localparam logic [CNT_W-1:0] MIN_W = CNT_W'(MIN_PULSE);
   localparam logic [CNT_W-1:0] SHORT = CNT_W'(SHORT_MAX);
   localparam logic [CNT_W-1:0] LONG  = CNT_W'(LONG_MIN);
   localparam logic [2:0]       BMIN  = 3'(BROAD_MIN);

   state_t           state;
   state_t           state_n;
   logic             level;
   logic             do_fall;
   logic             do_eval;
   logic             accept;
   logic [1:0]       kind;
   logic [CNT_W-1:0] period_cnt;
   logic [CNT_W-1:0] width_cnt;
   logic [CNT_W-1:0] fall_period;
   logic [2:0]       broad_cnt;
   logic             first_flag;

   csync_pulse_timer_sync_deglitch #(
      .GLITCH(GLITCH)
   ) u_sync (
      .clk  (clk),
      .rst  (rst),
      .din  (csync_in),
      .level(level)
   );

   assign sync_level = level;

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_n;
   end

   // Dropping enable overrides any edge seen in the same cycle.
   always_comb begin
      state_n = state;
      do_fall = 1'b0;
      do_eval = 1'b0;
      if (!enable) begin
         state_n = ST_IDLE;
      end else begin
         unique case (state)
            ST_IDLE: if (level) state_n = ST_HIGH;
            ST_HIGH: if (!level) begin
               state_n = ST_LOW;
               do_fall = 1'b1;
            end
            ST_LOW: if (level) begin
               state_n = ST_HIGH;
               do_eval = 1'b1;
            end
            default: state_n = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      accept = do_eval && (width_cnt >= MIN_W);
      if (width_cnt < SHORT)      kind = KIND_EQU;
      else if (width_cnt >= LONG) kind = KIND_BROAD;
      else                        kind = KIND_HSYNC;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pulse_valid  <= 1'b0;
         pulse_kind   <= KIND_NONE;
         pulse_width  <= '0;
         pulse_period <= '0;
         period_valid <= 1'b0;
         frame_start  <= 1'b0;
         period_cnt   <= '0;
         width_cnt    <= '0;
         fall_period  <= '0;
         broad_cnt    <= '0;
         first_flag   <= 1'b1;
      end else begin
         pulse_valid <= 1'b0;
         frame_start <= 1'b0;
         if (!enable) begin
            period_cnt  <= '0;
            width_cnt   <= '0;
            fall_period <= '0;
            broad_cnt   <= '0;
            first_flag  <= 1'b1;
         end else begin
            if (state != ST_IDLE && period_cnt != CMAX)
               period_cnt <= period_cnt + 1'b1;
            if (state == ST_LOW && width_cnt != CMAX)
               width_cnt <= width_cnt + 1'b1;
            if (do_fall) begin
               fall_period <= period_cnt;
               width_cnt   <= CNT_W'(1);
            end
            // Restart the period count as if it had run from the accepted fall.
            if (accept) begin
               pulse_valid  <= 1'b1;
               pulse_kind   <= kind;
               pulse_width  <= width_cnt;
               pulse_period <= fall_period;
               period_valid <= ~first_flag;
               frame_start  <= (kind == KIND_HSYNC) && (broad_cnt >= BMIN);
               first_flag   <= 1'b0;
               period_cnt   <= (width_cnt == CMAX) ? CMAX : width_cnt + 1'b1;
               unique case (kind)
                  KIND_BROAD: if (broad_cnt != 3'd7) broad_cnt <= broad_cnt + 3'd1;
                  KIND_HSYNC: broad_cnt <= '0;
                  default:    ;
               endcase
            end
         end
      end
   end

endmodule
